// File: rtl/unified_cache_packet_arbiter.sv
// unified_cache_packet_arbiter: round-robin merge of requester packets into the unified cache input
module unified_cache_packet_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_LEN   = 32,
  parameter int DATA_LEN   = 64,
  parameter int TYPE_LEN   = 4,
  parameter int MASK_LEN   = 8,
  parameter int PORT_LEN   = 4,
  parameter int PACKET_LEN = ADDR_LEN + DATA_LEN + TYPE_LEN + MASK_LEN + PORT_LEN + 3
) (
  input  logic                            clk_in,
  input  logic                            reset_in,
  input  logic [NUM_PORTS*PACKET_LEN-1:0] request_packet_flatted_in,
  output logic [NUM_PORTS-1:0]            request_ack_out,
  output logic [PACKET_LEN-1:0]           packet_out,
  input  logic                            packet_ack_in
);
  localparam int IDX_W   = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
  localparam int VALID   = PACKET_LEN - 3;
  localparam int PORT_HI = PACKET_LEN - 4;
  if (NUM_PORTS > 2 ** PORT_LEN) begin : g_port_chk
    $error("NUM_PORTS exceeds PORT_LEN capacity");
  end
  if (PACKET_LEN != ADDR_LEN + DATA_LEN + TYPE_LEN + MASK_LEN + PORT_LEN + 3) begin : g_len_chk
    $error("PACKET_LEN does not match field widths");
  end
  typedef enum logic {IDLE, SEND} state_t;
  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic [PACKET_LEN-1:0]  pkt_q, pkt_d;
  logic [NUM_PORTS-1:0]   ack_q, ack_d;
  logic                   hit;
  logic [IDX_W-1:0]       g;
  int                     idx;
  logic [PACKET_LEN-1:0]  gpkt;
  // first requesting port after last grant, wrapping
  always_comb begin
    hit = 1'b0;
    g   = '0;
    idx = 0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = (int'(last_q) + k) % NUM_PORTS;
      if (!hit && request_packet_flatted_in[idx*PACKET_LEN+VALID]) begin
        hit = 1'b1;
        g   = IDX_W'(idx);
      end
    end
    gpkt = request_packet_flatted_in[int'(g)*PACKET_LEN +: PACKET_LEN];
    gpkt[PORT_HI -: PORT_LEN] = PORT_LEN'(g);
  end
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    pkt_d   = pkt_q;
    ack_d   = '0;
    if (state_q == IDLE) begin
      if (hit) begin
        pkt_d   = gpkt;
        ack_d   = {{(NUM_PORTS-1){1'b0}}, 1'b1} << g;
        last_d  = g;
        state_d = SEND;
      end
    end else if (packet_ack_in) begin
      pkt_d   = '0;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q <= IDLE;
      last_q  <= IDX_W'(NUM_PORTS - 1);
      pkt_q   <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      pkt_q   <= pkt_d;
      ack_q   <= ack_d;
    end
  end
  assign packet_out      = pkt_q;
  assign request_ack_out = ack_q;
endmodule

// File: tb/tb_unified_cache_packet_arbiter.sv
// tb_unified_cache_packet_arbiter: directed vectors for the round-robin cache packet arbiter
module tb_unified_cache_packet_arbiter;
  localparam int NP = 4;
  localparam int PL = 115;
  logic              clk_in = 1'b0;
  logic              reset_in;
  logic [NP*PL-1:0]  req_flat;
  logic [NP-1:0]     ack_out;
  logic [PL-1:0]     pkt_out;
  logic              pkt_ack;
  logic [PL-1:0]     req [NP];
  int                n_vec = 0;
  int                n_bad = 0;
  logic [PL-1:0]     held;
  unified_cache_packet_arbiter #(
    .NUM_PORTS(NP), .ADDR_LEN(32), .DATA_LEN(64), .TYPE_LEN(4), .MASK_LEN(8), .PORT_LEN(4),
    .PACKET_LEN(PL)
  ) dut (
    .clk_in                    (clk_in),
    .reset_in                  (reset_in),
    .request_packet_flatted_in (req_flat),
    .request_ack_out           (ack_out),
    .packet_out                (pkt_out),
    .packet_ack_in             (pkt_ack)
  );
  always #5 clk_in = ~clk_in;
  always_comb for (int i = 0; i < NP; i++) req_flat[i*PL +: PL] = req[i];
  function automatic logic [PL-1:0] pk(input int p, input logic [3:0] pf);
    return {1'(p % 2), 1'(p / 2), 1'b1, pf, 8'(8'h11 * (p + 1)), 4'(p + 5),
            64'(64'hDA7A_0000_0000_0000 + p), 32'(32'h1000_0000 + p * 64)};
  endfunction
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask
  task automatic clear_req;
    for (int i = 0; i < NP; i++) req[i] = '0;
  endtask
  task automatic do_reset;
    reset_in = 1'b1;
    tick();
    tick();
    reset_in = 1'b0;
  endtask
  initial begin
    int seq [5] = '{0, 1, 2, 3, 0};
    int skp [3] = '{3, 1, 3};
    pkt_ack = 1'b0;
    clear_req();
    do_reset();
    chk("rst_pkt", pkt_out, 0);
    chk("rst_ack", ack_out, 0);
    // all ports request, cache acks immediately: rotation 0,1,2,3,0
    for (int i = 0; i < NP; i++) req[i] = pk(i, 4'hF);
    pkt_ack = 1'b1;
    foreach (seq[i]) begin
      tick();
      chk($sformatf("rot%0d_ack", i), ack_out, 4'b1 << seq[i]);
      chk($sformatf("rot%0d_pkt", i), pkt_out, pk(seq[i], 4'(seq[i])));
      tick();
      chk($sformatf("rot%0d_pulse", i), ack_out, 0);
      chk($sformatf("rot%0d_drop", i), pkt_out, 0);
    end
    pkt_ack = 1'b0;
    clear_req();
    // single request from port 2 after fresh reset
    do_reset();
    req[2] = {1'b1, 1'b1, 1'b1, 4'h0, 8'hA5, 4'h3, 64'hCAFE_F00D_1234_5678, 32'h0000_1000};
    tick();
    chk("single_ack", ack_out, 4'b0100);
    chk("single_pkt", pkt_out,
        {1'b1, 1'b1, 1'b1, 4'h2, 8'hA5, 4'h3, 64'hCAFE_F00D_1234_5678, 32'h0000_1000});
    chk("single_addr", pkt_out[31:0], 32'h0000_1000);
    tick();
    chk("single_pulse", ack_out, 0);
    pkt_ack = 1'b1;
    clear_req();
    tick();
    chk("single_done", pkt_out, 0);
    pkt_ack = 1'b0;
    // backpressure: last grant 2, port 3 granted, port 1 waits
    req[3] = pk(3, 4'h9);
    tick();
    chk("bp_grant", ack_out, 4'b1000);
    held = pk(3, 4'h3);
    req[3] = '0;
    req[1] = pk(1, 4'h7);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("bp%0d_pkt", i), pkt_out, held);
      chk($sformatf("bp%0d_ack", i), ack_out, 0);
    end
    pkt_ack = 1'b1;
    tick();
    chk("bp_release", pkt_out, 0);
    pkt_ack = 1'b0;
    tick();
    chk("bp_p1_ack", ack_out, 4'b0010);
    chk("bp_p1_pkt", pkt_out, pk(1, 4'h1));
    pkt_ack = 1'b1;
    clear_req();
    tick();
    // skip idle ports: last grant 1, ports 1 and 3 request
    req[1] = pk(1, 4'h0);
    req[3] = pk(3, 4'h0);
    foreach (skp[i]) begin
      tick();
      chk($sformatf("skip%0d_ack", i), ack_out, 4'b1 << skp[i]);
      chk($sformatf("skip%0d_pkt", i), pkt_out, pk(skp[i], 4'(skp[i])));
      if (i < 2) begin
        tick();
        chk($sformatf("skip%0d_idle", i), ack_out, 0);
      end
    end
    // reset while holding port 3 packet
    pkt_ack = 1'b0;
    reset_in = 1'b1;
    tick();
    chk("rsend_pkt", pkt_out, 0);
    chk("rsend_ack", ack_out, 0);
    reset_in = 1'b0;
    for (int i = 0; i < NP; i++) req[i] = pk(i, 4'hC);
    tick();
    chk("rsend_restart", ack_out, 4'b0001);
    chk("rsend_pkt0", pkt_out, pk(0, 4'h0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
